// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generator, pipelined ROM interface, prefetch queue and branch redirect.
// Optional feature: define DELAY_SLOT_EN to keep one delay-slot instruction across a redirect.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_gnt,
    input  logic              rom_rvalid,
    input  logic [INST_W-1:0] rom_data_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     CAP  = CW'(DEPTH);
    localparam logic [CW-1:0]     ONE  = CW'(1);
    localparam logic [PW-1:0]     PONE = PW'(1);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

`ifdef DELAY_SLOT_EN
    typedef enum logic [2:0] {BOOT, RUN, DRAIN, KEEP, SLOT} state_t;
    localparam logic [PW-1:0] PTWO = PW'(2);
    logic [ADDR_W-1:0] pending;
    logic [CW-1:0]     q_after;
`else
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
`endif

    state_t state;

    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] f_pc   [DEPTH];
    logic [PW-1:0]     q_rd, q_wr, f_rd, f_wr;
    logic [CW-1:0]     q_count, inflight, discard, inflight_n;
    logic              hs, pop, push, redirect;

    always_comb begin
        rom_req = 1'b0;
        case (state)
            RUN:     rom_req = (q_count + inflight) < CAP;
`ifdef DELAY_SLOT_EN
            SLOT:    rom_req = 1'b1;
`endif
            default: rom_req = 1'b0;
        endcase
    end

    assign hs         = rom_req & rom_gnt;
    assign id_valid_o = (q_count != '0);
    assign pop        = id_valid_o & id_ready_i;
    assign redirect   = pop & branch_flag_i;
    assign push       = rom_rvalid & (state != DRAIN);
    assign inflight_n = inflight + CW'(hs) - CW'(rom_rvalid);
    assign id_pc      = id_valid_o ? q_pc[q_rd] : '0;
    assign id_inst    = id_valid_o ? q_inst[q_rd] : '0;
`ifdef DELAY_SLOT_EN
    assign q_after    = q_count - ONE + CW'(push);
`endif

    // Storage arrays carry no reset; validity is tracked by the counters below.
    always_ff @(posedge clk) begin
        if (hs)
            f_pc[f_wr] <= rom_addr_o;
        if (push) begin
            q_pc[q_wr]   <= f_pc[f_rd];
            q_inst[q_wr] <= rom_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            rom_ce     <= 1'b0;
            rom_addr_o <= RESET_PC;
            q_rd       <= '0;
            q_wr       <= '0;
            f_rd       <= '0;
            f_wr       <= '0;
            q_count    <= '0;
            inflight   <= '0;
            discard    <= '0;
`ifdef DELAY_SLOT_EN
            pending    <= '0;
`endif
        end else begin
            inflight <= inflight_n;
            q_count  <= q_count + CW'(push) - CW'(pop);
            if (hs) begin
                f_wr       <= f_wr + PONE;
                rom_addr_o <= rom_addr_o + STEP;
            end
            if (rom_rvalid)
                f_rd <= f_rd + PONE;
            if (push)
                q_wr <= q_wr + PONE;
            if (pop)
                q_rd <= q_rd + PONE;

            case (state)
                BOOT: begin
                    state  <= RUN;
                    rom_ce <= 1'b1;
                end
                DRAIN: if (rom_rvalid) begin
                    discard <= discard - ONE;
                    if (discard == ONE)
                        state <= RUN;
                end
`ifdef DELAY_SLOT_EN
                KEEP: if (rom_rvalid)
                    state <= (discard != '0) ? DRAIN : RUN;
                SLOT: if (hs) begin
                    rom_addr_o <= pending;
                    state      <= RUN;
                end
`endif
                default: ;
            endcase

            // Redirect overrides the normal queue/PC updates above; a same-cycle response is not stale.
            if (redirect) begin
                rom_addr_o <= branch_target_address_i;
`ifdef DELAY_SLOT_EN
                if (q_after != '0) begin
                    // Entry after the popped head sits at q_rd+1, whether already queued or pushed now.
                    q_count <= ONE;
                    q_rd    <= q_rd + PONE;
                    q_wr    <= q_rd + PTWO;
                    discard <= inflight_n;
                    state   <= (inflight_n != '0) ? DRAIN : RUN;
                end else begin
                    q_count <= '0;
                    q_rd    <= '0;
                    q_wr    <= '0;
                    if (inflight_n != '0) begin
                        discard <= inflight_n - ONE;
                        state   <= KEEP;
                    end else begin
                        rom_addr_o <= rom_addr_o;
                        pending    <= branch_target_address_i;
                        state      <= SLOT;
                    end
                end
`else
                q_count <= '0;
                q_rd    <= '0;
                q_wr    <= '0;
                discard <= inflight_n;
                state   <= (inflight_n != '0) ? DRAIN : RUN;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model with selectable latency, decode model with branch injection,
// and a scoreboard of expected (pc, inst) pops consumed by an independent monitor.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce, rom_req, rom_gnt = 1'b0, rom_rvalid = 1'b0;
    logic [31:0] rom_addr_o, rom_data_i = '0;
    logic        id_valid_o, id_ready_i = 1'b0, branch_flag_i = 1'b0;
    logic [31:0] id_pc, id_inst, branch_target_address_i = '0;

    fetch_unit #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rom_ce(rom_ce), .rom_req(rom_req), .rom_addr_o(rom_addr_o),
        .rom_gnt(rom_gnt), .rom_rvalid(rom_rvalid), .rom_data_i(rom_data_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc(id_pc), .id_inst(id_inst),
        .branch_flag_i(branch_flag_i),
        .branch_target_address_i(branch_target_address_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } rom_t;

    rom_t        rom_q[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc = 0, hs_count = 0, pops_left = 0, lat = 1;
    bit          ready_en = 1'b0, br_armed = 1'b0;
    logic [31:0] br_pc = '0, br_tgt = '0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(base + 32'(4 * i));
    endtask

    // ROM and decode drivers: inputs change only on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            rom_q.delete();
            rom_rvalid    = 1'b0;
            rom_data_i    = '0;
            rom_gnt       = 1'b0;
            id_ready_i    = 1'b0;
            branch_flag_i = 1'b0;
            hs_count      = 0;
            cyc           = 0;
        end else begin
            cyc++;
            rom_rvalid = 1'b0;
            rom_data_i = '0;
            if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
                rom_rvalid = 1'b1;
                rom_data_i = inst_of(rom_q[0].addr);
                void'(rom_q.pop_front());
            end
            rom_gnt = 1'b1;
            if (rom_req && rom_gnt) begin
                rom_q.push_back('{rom_addr_o, cyc + lat});
                hs_count++;
            end
            id_ready_i = ready_en && (pops_left > 0);
            branch_flag_i = br_armed && id_valid_o && id_ready_i && (id_pc == br_pc);
            branch_target_address_i = br_tgt;
            if (id_valid_o && id_ready_i) begin
                pops_left--;
                if (branch_flag_i)
                    br_armed = 1'b0;
            end
        end
    end

    // Monitor: every pop decode performs is matched against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (rst && id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop: unexpected pop id_pc=0x%0h, want no pop", id_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pop_pc", id_pc, e);
                check("pop_inst", id_inst, inst_of(e));
            end
        end
    end

    task automatic start(input int unsigned l, input bit rdy, input bit arm,
                         input logic [31:0] bpc, input logic [31:0] btgt);
        rst = 1'b0;
        #1;
        lat = l; ready_en = rdy; br_armed = arm; br_pc = bpc; br_tgt = btgt;
        pops_left = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d pops missing at timeout, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        check("rst_rom_req", 32'(rom_req), 32'd0);
        check("rst_rom_addr", rom_addr_o, 32'h0);
        check("rst_id_valid", 32'(id_valid_o), 32'd0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);

        // 1: boot timing and one-per-cycle stream
        start(1, 1'b1, 1'b0, '0, '0);
        push_run(32'h0, 8);
        pops_left = 8;
        check("t1_ce_release", 32'(rom_ce), 32'd0);
        @(negedge clk); #3;
        check("t1_ce_k1", 32'(rom_ce), 32'd1);
        check("t1_req_k1", 32'(rom_req), 32'd1);
        check("t1_valid_k1", 32'(id_valid_o), 32'd0);
        @(negedge clk); #3;
        check("t1_valid_k2", 32'(id_valid_o), 32'd0);
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk); #3;
            check("t1_stream_valid", 32'(id_valid_o), 32'd1);
        end
        wait_done("t1_done");

        // 2: back-pressure fills DEPTH slots, then drains in order
        start(1, 1'b0, 1'b0, '0, '0);
        repeat (10) @(negedge clk);
        #3;
        check("t2_hs_cap", hs_count, 32'd4);
        check("t2_req_stop", 32'(rom_req), 32'd0);
        check("t2_head_hold", id_pc, 32'h0);
        push_run(32'h0, 8);
        pops_left = 8;
        ready_en = 1'b1;
        wait_done("t2_done");
        check("t2_resume", 32'(hs_count >= 8), 32'd1);

        // 3/4: redirect at 0x10 with fetches in flight
        start(2, 1'b1, 1'b1, 32'h10, 32'h100);
        push_run(32'h0, 5);
`ifdef DELAY_SLOT_EN
        exp_q.push_back(32'h14);
`endif
        push_run(32'h100, 3);
        pops_left = exp_q.size();
        wait_done("t3_done");
        check("t3_branch_taken", 32'(br_armed), 32'd0);

        // 5: 3-cycle ROM, full queue, redirect with a response arriving the same cycle
        start(3, 1'b0, 1'b1, 32'h10, 32'h200);
        repeat (12) @(negedge clk);
        #3;
        check("t5_hs_cap", hs_count, 32'd4);
        check("t5_req_stop", 32'(rom_req), 32'd0);
        push_run(32'h0, 5);
`ifdef DELAY_SLOT_EN
        exp_q.push_back(32'h14);
`endif
        push_run(32'h200, 2);
        pops_left = exp_q.size();
        ready_en = 1'b1;
        wait_done("t5_done");

        // 5b: redirect from the head of a full queue, nothing in flight
        start(1, 1'b0, 1'b1, 32'h0, 32'h300);
        repeat (8) @(negedge clk);
        #3;
        exp_q.push_back(32'h0);
`ifdef DELAY_SLOT_EN
        exp_q.push_back(32'h4);
`endif
        push_run(32'h300, 3);
        pops_left = exp_q.size();
        ready_en = 1'b1;
        wait_done("t5b_done");

        // 6: asynchronous reset with three fetches in flight
        start(3, 1'b0, 1'b0, '0, '0);
        begin
            int unsigned n = 0;
            while (hs_count < 3 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_hs_seen", hs_count, 32'd3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_ce", 32'(rom_ce), 32'd0);
        check("t6_rst_req", 32'(rom_req), 32'd0);
        check("t6_rst_addr", rom_addr_o, 32'h0);
        check("t6_rst_valid", 32'(id_valid_o), 32'd0);
        exp_q.delete();
        push_run(32'h0, 3);
        pops_left = 3;
        ready_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #3;
            check("t6_first_valid", 32'(id_valid_o), (k == 5) ? 32'd1 : 32'd0);
        end
        wait_done("t6_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage for the 5-stage core. It replaces the fixed PC register and IF/ID latch pair with the following:
- a PC generator;
- a pipelined ROM request/response interface with multi-cycle latency;
- a DEPTH-entry prefetch queue feeding decode under a valid/ready handshake;
- branch redirect with flush of stale in-flight fetches.

Sits between instruction ROM and the decode stage. Branch outcome comes back from decode.

Parameters:
ADDR_W, 32, PC / ROM address width
INST_W, 32, instruction width
DEPTH, 4, prefetch queue entries and maximum in-flight requests; power of two, >=2
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rom_ce  out  1  ROM enable; 0 in reset and for one cycle after release, 1 otherwise
rom_req  out  1  fetch request valid
rom_addr_o  out  ADDR_W  fetch address; registered
rom_gnt  in  1  ROM accepts request this cycle (handshake = rom_req & rom_gnt)
rom_rvalid  in  1  response valid; in-order, exactly one per accepted request, earliest 1 cycle after accept
rom_data_i  in  INST_W  response instruction
id_valid_o  out  1  queue head valid to decode
id_ready_i  in  1  decode accepts head (pop = id_valid_o & id_ready_i)
id_pc  out  ADDR_W  PC of head entry
id_inst  out  INST_W  instruction of head entry
branch_flag_i  in  1  redirect request; honoured only in a pop cycle, ignored otherwise
branch_target_address_i  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, except rom_addr_o=RESET_PC. Queue empty, in-flight count 0, discard count 0, FSM=BOOT.
- FSM states:
  - BOOT: rom_ce=0, one cycle, then RUN.
  - RUN: normal fetch.
  - DRAIN: discard count >0.
  - DRAIN -> RUN when the discard count reaches 0.
- Request rule (RUN only): rom_req=1 iff queue_count + inflight < DEPTH.
  - On handshake: inflight++, rom_addr_o += PC_STEP (wraps modulo 2^ADDR_W).
  - The queue therefore can never overflow; each response writes the queue tail with {pc, inst}, and the pc is tracked per in-flight slot.
- Latency: request at cycle t, rvalid at t+1 -> id_valid_o at t+2. No bypass.
- Simultaneous push and pop: both happen; the count is unchanged.
- Simultaneous rvalid and new request: inflight is unchanged.
- Redirect (branch_flag_i in a pop cycle), without the optional feature:
  - Queue is cleared, including any same-cycle push.
  - Discard count = inflight, minus 1 if rom_rvalid in the same cycle.
  - rom_addr_o = branch_target_address_i.
  - Next state is DRAIN if the discard count >0, else RUN.
- DRAIN: rom_req=0; each rvalid decrements the discard count and is dropped.
- Redirect during a cycle where rom_req & rom_gnt: that accepted request counts as in-flight and is discarded.
- id_pc/id_inst hold their value while id_valid_o=1 and id_ready_i=0; they are 0 when the queue is empty.
- Reset asserted mid-operation: immediate return to the reset state. The ROM shares rst, so no stale responses arrive after release.

Optional Feature:
Macro DELAY_SLOT_EN.
- Defined: redirect preserves exactly one delay-slot instruction (the entry sequentially after the branch). Cases, checked in order:
  - (a) Queue holds >=1 entry after the pop: keep only the new head; discard all in-flight.
  - (b) Else if inflight >=1: keep the first arriving response; discard the rest.
  - (c) Else: issue one fetch at the current rom_addr_o, then load the target held in a pending register.
  - The target is fetched only after the delay slot is secured; in case (b) the target fetch is not issued before that response arrives.
- Undefined: full flush as above. The pending register and keep logic are absent.

Test Plan:
1. Reset release with gnt=1 and 1-cycle ROM, id_ready=1 -> rom_ce rises 1 cycle after release; id_pc sequence 0x0,0x4,0x8,0xC with one entry per cycle after the first id_valid_o.
2. DEPTH=4, id_ready=0 -> exactly 4 handshakes, then rom_req=0; on id_ready=1 entries 0x0..0xC pop in order with no loss, and requests resume.
3. Without DELAY_SLOT_EN: branch popped at pc 0x10 with 2 in flight, target 0x100 -> responses for 0x14/0x18 dropped; next id_pc=0x100.
4. With DELAY_SLOT_EN, same stimulus -> pops 0x10, 0x14, 0x100, 0x104.
5. ROM latency 3 cycles, redirect while queue full and rvalid in the same cycle -> no overflow; the discard count excludes the same-cycle response; next valid id_pc=target.
6. rst low while inflight=3 -> outputs reset the same cycle; after release, fetch restarts at RESET_PC with id_valid_o=0 until the first new response.
